// File: rtl/bids_pkg.sv
// Shared types and reset constants for the N-bidder auction controller.
package bids_pkg;

   typedef enum logic [3:0] {
      OP_NOP          = 4'd0,
      OP_SETINDEX     = 4'd1,
      OP_LOAD         = 4'd2,
      OP_SETMASK      = 4'd3,
      OP_SETTIMER     = 4'd4,
      OP_SETBIDCHARGE = 4'd5,
      OP_LOCK         = 4'd6,
      OP_UNLOCK       = 4'd7
   } op_t;

   typedef enum logic [2:0] {
      NOERROR            = 3'd0,
      CSTARTWHENUNLOCKED = 3'd1,
      ALREADYUNLOCKED    = 3'd2,
      INVALID_OP         = 3'd3,
      BADKEY             = 3'd4
   } err_t;

   typedef enum logic [1:0] {
      NOBIDERROR        = 2'd0,
      INVALIDREQUEST    = 2'd1,
      INSUFFICIENTFUNDS = 2'd2
   } biderr_t;

   typedef enum logic [2:0] {
      UNLOCKED = 3'd0,
      LOCKED   = 3'd1,
      COOLDOWN = 3'd2,
      ROUND    = 3'd3,
      RESULT   = 3'd4
   } state_t;

   localparam int unsigned RST_TIMER  = 15;
   localparam int unsigned RST_CHARGE = 1;

endpackage

// File: rtl/bid_max_select.sv
// Combinational max finder over all escrowed bids; ties resolve to the lowest index.
// An all-zero input produces no winner.
module bid_max_select #(
   parameter int DATAWIDTH  = 32,
   parameter int NUMBIDDERS = 4
) (
   input  logic [NUMBIDDERS*DATAWIDTH-1:0] vals,
   output logic [DATAWIDTH-1:0]            max_val,
   output logic [NUMBIDDERS-1:0]           win_onehot
);

   always_comb begin
      // NOTE: every output gets a default before the loop, so no latch is inferred.
      max_val    = '0;
      win_onehot = '0;
      // Strict '>' keeps the earliest (lowest-index) bidder on equal values.
      for (int i = 0; i < NUMBIDDERS; i++) begin
         if (vals[i*DATAWIDTH +: DATAWIDTH] > max_val) begin
            max_val       = vals[i*DATAWIDTH +: DATAWIDTH];
            win_onehot    = '0;
            win_onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bids_auction_n.sv
// N-bidder escrowed auction controller: host FSM, per-bidder escrow datapath,
// and registered round results.
module bids_auction_n
   import bids_pkg::*;
#(
   parameter int DATAWIDTH  = 32,
   parameter int NUMBIDDERS = 4,
   parameter int IDXW       = $clog2(NUMBIDDERS)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [3:0]                      C_op,
   input  logic [DATAWIDTH-1:0]            C_data,
   input  logic                            C_start,
   input  logic [NUMBIDDERS-1:0]           bid,
   input  logic [NUMBIDDERS*DATAWIDTH-1:0] bidAmt,
   input  logic [NUMBIDDERS-1:0]           retract,
   output logic                            ready,
   output logic [2:0]                      err,
   output logic                            roundOver,
   output logic [DATAWIDTH-1:0]            maxBid,
   output logic [NUMBIDDERS-1:0]           win,
   output logic [NUMBIDDERS*DATAWIDTH-1:0] balance,
   output logic [NUMBIDDERS*2-1:0]         bidErr
);

   localparam logic [DATAWIDTH-1:0] NB_LIMIT = DATAWIDTH'(NUMBIDDERS);

   state_t                          state_q, state_d;
   logic [DATAWIDTH-1:0]            key_q, key_d, timer_q, timer_d;
   logic [DATAWIDTH-1:0]            charge_q, charge_d, cnt_q, cnt_d;
   logic [IDXW-1:0]                 index_q, index_d;
   logic [NUMBIDDERS-1:0]           mask_q, mask_d;
   logic                            ready_q, round_over_q;
   logic [DATAWIDTH-1:0]            max_bid_q, sel_max;
   logic [NUMBIDDERS-1:0]           win_q, sel_win;
   logic [NUMBIDDERS*DATAWIDTH-1:0] lastbid_d_flat;
   err_t                            err_c;
   op_t                             op;
   logic                            load_en;

   always_comb begin
      op       = op_t'(C_op);
      state_d  = state_q;
      key_d    = key_q;
      index_d  = index_q;
      mask_d   = mask_q;
      timer_d  = timer_q;
      charge_d = charge_q;
      cnt_d    = cnt_q;
      err_c    = NOERROR;
      load_en  = 1'b0;
      case (state_q)
         UNLOCKED: begin
            if (C_start) begin
               err_c = CSTARTWHENUNLOCKED;
            end else begin
               case (op)
                  OP_NOP: ;
                  OP_SETINDEX: begin
                     // Range-check the whole operand so stray high bits never alias a bidder.
                     if (C_data < NB_LIMIT) index_d = C_data[IDXW-1:0];
                     else                   err_c   = INVALID_OP;
                  end
                  OP_LOAD:         load_en  = 1'b1;
                  OP_SETMASK:      mask_d   = C_data[NUMBIDDERS-1:0];
                  OP_SETTIMER:     timer_d  = C_data;
                  OP_SETBIDCHARGE: charge_d = C_data;
                  OP_LOCK: begin
                     key_d   = C_data;
                     state_d = LOCKED;
                  end
                  OP_UNLOCK:       err_c    = ALREADYUNLOCKED;
                  default:         err_c    = INVALID_OP;
               endcase
            end
         end
         LOCKED: begin
            if (C_start) begin
               state_d = ROUND;
            end else if (op == OP_UNLOCK) begin
               if (C_data == key_q) begin
                  state_d = UNLOCKED;
               end else begin
                  err_c   = BADKEY;
                  cnt_d   = timer_q;
                  state_d = COOLDOWN;
               end
            end else if (op != OP_NOP) begin
               err_c = INVALID_OP;
            end
         end
         COOLDOWN: begin
            err_c = BADKEY;
            if (cnt_q == '0) state_d = LOCKED;
            else             cnt_d   = cnt_q - DATAWIDTH'(1);
         end
         ROUND: begin
            if (op != OP_NOP) err_c = INVALID_OP;
            if (!C_start)     state_d = RESULT;
         end
         RESULT:  state_d = LOCKED;
         default: state_d = UNLOCKED;
      endcase
   end

   // Results are sampled from next-cycle escrow so they appear in the RESULT cycle itself.
   bid_max_select #(
      .DATAWIDTH  (DATAWIDTH),
      .NUMBIDDERS (NUMBIDDERS)
   ) u_max_select (
      .vals       (lastbid_d_flat),
      .max_val    (sel_max),
      .win_onehot (sel_win)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= UNLOCKED;
         key_q        <= '0;
         index_q      <= '0;
         mask_q       <= '1;
         timer_q      <= DATAWIDTH'(RST_TIMER);
         charge_q     <= DATAWIDTH'(RST_CHARGE);
         cnt_q        <= '0;
         ready_q      <= 1'b0;
         round_over_q <= 1'b0;
         max_bid_q    <= '0;
         win_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         key_q        <= key_d;
         index_q      <= index_d;
         mask_q       <= mask_d;
         timer_q      <= timer_d;
         charge_q     <= charge_d;
         cnt_q        <= cnt_d;
         ready_q      <= (state_d == LOCKED);
         round_over_q <= (state_d == RESULT);
         max_bid_q    <= (state_d == RESULT) ? sel_max : '0;
         win_q        <= (state_d == RESULT) ? sel_win : '0;
      end
   end

   for (genvar g = 0; g < NUMBIDDERS; g++) begin : g_bidder
      logic [DATAWIDTH-1:0] amt, bal_q, bal_d, last_q, last_d;
      logic [DATAWIDTH:0]   cost, refund_sum;
      biderr_t              berr;

      assign amt = bidAmt[g*DATAWIDTH +: DATAWIDTH];

      always_comb begin
         bal_d      = bal_q;
         last_d     = last_q;
         berr       = NOBIDERROR;
         cost       = {1'b0, amt - last_q} + {1'b0, charge_q};
         refund_sum = {1'b0, bal_q} + {1'b0, last_q};
         case (state_q)
            UNLOCKED: if (load_en && index_q == IDXW'(g)) bal_d = C_data;
            ROUND: begin
               if (bid[g]) begin
                  if (!mask_q[g] || amt <= last_q) begin
                     berr = INVALIDREQUEST;
                  end else if (cost > {1'b0, bal_q}) begin
                     berr = INSUFFICIENTFUNDS;
                  end else begin
                     bal_d  = bal_q - cost[DATAWIDTH-1:0];
                     last_d = amt;
                  end
               end else if (retract[g]) begin
                  bal_d  = refund_sum[DATAWIDTH] ? '1 : refund_sum[DATAWIDTH-1:0];
                  last_d = '0;
               end
            end
            RESULT: begin
               if (!win_q[g]) bal_d = refund_sum[DATAWIDTH] ? '1 : refund_sum[DATAWIDTH-1:0];
               last_d = '0;
            end
            default: ;
         endcase
      end

      // NOTE: balances and escrow are plain reset registers; reset drops escrow unrefunded.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            bal_q  <= '0;
            last_q <= '0;
         end else begin
            bal_q  <= bal_d;
            last_q <= last_d;
         end
      end

      assign balance[g*DATAWIDTH +: DATAWIDTH]        = bal_q;
      assign lastbid_d_flat[g*DATAWIDTH +: DATAWIDTH] = last_d;
      assign bidErr[g*2 +: 2]                         = berr;
   end

   assign ready     = ready_q;
   assign err       = err_c;
   assign roundOver = round_over_q;
   assign maxBid    = max_bid_q;
   assign win       = win_q;

endmodule
